// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory port controller.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  // Wide all-ones lane mask; users truncate to their own byte-enable width.
  localparam int unsigned        BE_ALL_W = 128;
  localparam logic [BE_ALL_W-1:0] BE_ALL  = '1;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Bus wait counter: expire_c asserts on the LIMIT-th enabled cycle since the last clear.
module mem_timeout_cnt #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire_c = enable && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_port_ctrl.sv
// Single-outstanding bridge from the arbitrated core request to the valid/ready memory bus.
// Optional bus timeout is built when MEM_TIMEOUT_EN is defined.
module mem_port_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_RDATA      = DATA_W'(32'h0000_0013)
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_rw,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_byte_en,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  bus_valid,
  input  logic                  bus_ready,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic                  bus_we,
  output logic [DATA_W-1:0]     bus_wdata,
  output logic [DATA_W/8-1:0]   bus_be,
  input  logic [DATA_W-1:0]     bus_rdata
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e state;

`ifdef MEM_TIMEOUT_EN
  logic timeout_c;
  logic tmo_clear;
  logic tmo_enable;

  assign tmo_clear  = (state != REQ);
  assign tmo_enable = (state == REQ) && !bus_ready;

  mem_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmo_clear),
    .enable   (tmo_enable),
    .expire_c (timeout_c)
  );
`endif

  // The bus_* registers double as the captured request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      bus_valid <= 1'b0;
      bus_addr  <= '0;
      bus_we    <= 1'b0;
      bus_wdata <= '0;
      bus_be    <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
            bus_addr  <= req_addr & ~ADDR_W'(3);
            bus_we    <= req_rw;
            bus_wdata <= req_wdata;
            bus_be    <= (req_rw == MEM_READ) ? BE_W'(BE_ALL) : req_byte_en;
            // A write with no lanes enabled retires without touching the bus.
            if ((req_rw == MEM_WRITE) && (req_byte_en == '0)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= '0;
              rsp_err   <= 1'b0;
            end else begin
              state     <= REQ;
              bus_valid <= 1'b1;
            end
          end
        end
        REQ: begin
          if (bus_ready) begin
            state     <= RESP;
            bus_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= (bus_we == MEM_WRITE) ? '0 : bus_rdata;
            rsp_err   <= 1'b0;
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout_c) begin
            state     <= RESP;
            bus_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= ERR_RDATA;
            rsp_err   <= 1'b1;
          end
`endif
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          bus_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: vector table of single accesses plus multi-cycle sequences.
module tb_mem_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_rw;
  logic [31:0] req_wdata;
  logic [3:0]  req_byte_en;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_port_ctrl #(
    .ADDR_W (32),
    .DATA_W (32)
`ifdef MEM_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_rw      (req_rw),
    .req_wdata   (req_wdata),
    .req_byte_en (req_byte_en),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .bus_addr    (bus_addr),
    .bus_we      (bus_we),
    .bus_wdata   (bus_wdata),
    .bus_be      (bus_be),
    .bus_rdata   (bus_rdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_rdata;
    logic        exp_bus;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic [31:0] addr, input logic rw,
                           input logic [31:0] wdata, input logic [3:0] be);
    req_valid   = 1'b1;
    req_addr    = addr;
    req_rw      = rw;
    req_wdata   = wdata;
    req_byte_en = be;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0104, 1'b0, 32'h0,         4'h0, 0, 32'h00A0_0093,
                32'h0000_0104, 4'hF, 32'h00A0_0093, 1'b1};
    vecs[1] = '{32'h0000_0040, 1'b1, 32'h5555_AAAA, 4'h0, 0, 32'hFFFF_FFFF,
                32'h0000_0040, 4'h0, 32'h0,         1'b0};
    vecs[2] = '{32'h0000_2000, 1'b1, 32'hCAFE_F00D, 4'h3, 3, 32'hFFFF_FFFF,
                32'h0000_2000, 4'h3, 32'h0,         1'b1};
    vecs[3] = '{32'h7FFF_FFFB, 1'b0, 32'h0,         4'h5, 1, 32'h1234_5678,
                32'h7FFF_FFF8, 4'hF, 32'h1234_5678, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 1'b0, 32'h0,         4'h0, 2, 32'hDEAD_BEEF,
                32'hFFFF_FFFC, 4'hF, 32'hDEAD_BEEF, 1'b1};

    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_addr    = '0;
    req_rw      = 1'b0;
    req_wdata   = '0;
    req_byte_en = '0;
    bus_ready   = 1'b0;
    bus_rdata   = '0;
    repeat (3) @(negedge clk);

    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_busy",      32'(busy),      32'd0);
    chk("reset_bus_valid", 32'(bus_valid), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata,      32'd0);
    chk("reset_bus_addr",  bus_addr,       32'd0);
    chk("reset_bus_be",    32'(bus_be),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single accesses
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("v%0d_idle_ready", i), 32'(req_ready), 32'd1);
      drive_req(vecs[i].addr, vecs[i].rw, vecs[i].wdata, vecs[i].be);
      @(negedge clk);
      req_valid = 1'b0;
      if (vecs[i].exp_bus) begin
        for (int w = 0; w <= vecs[i].waits; w++) begin
          chk($sformatf("v%0d_c%0d_bus_valid", i, w), 32'(bus_valid), 32'd1);
          chk($sformatf("v%0d_c%0d_bus_addr",  i, w), bus_addr,       vecs[i].exp_addr);
          chk($sformatf("v%0d_c%0d_bus_we",    i, w), 32'(bus_we),    32'(vecs[i].rw));
          chk($sformatf("v%0d_c%0d_bus_be",    i, w), 32'(bus_be),    32'(vecs[i].exp_be));
          chk($sformatf("v%0d_c%0d_bus_wdata", i, w), bus_wdata,      vecs[i].wdata);
          chk($sformatf("v%0d_c%0d_busy",      i, w), 32'(busy),      32'd1);
          chk($sformatf("v%0d_c%0d_rsp_quiet", i, w), 32'(rsp_valid), 32'd0);
          chk($sformatf("v%0d_c%0d_no_accept", i, w), 32'(req_ready), 32'd0);
          if (w == vecs[i].waits) begin
            bus_ready = 1'b1;
            bus_rdata = vecs[i].rdata;
          end
          @(negedge clk);
        end
        bus_ready = 1'b0;
        bus_rdata = 32'hBAD0_BAD0;
      end
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata,      vecs[i].exp_rdata);
      chk($sformatf("v%0d_rsp_err",   i), 32'(rsp_err),   32'd0);
      chk($sformatf("v%0d_rsp_bus_valid", i), 32'(bus_valid), 32'd0);
      chk($sformatf("v%0d_rsp_req_ready", i), 32'(req_ready), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_rsp_pulse", i), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d_rdata_hold", i), rsp_rdata,    vecs[i].exp_rdata);
      chk($sformatf("v%0d_back_idle", i), 32'(busy),      32'd0);
    end

    // Back-to-back: second request held on req_valid while the first is in flight
    drive_req(32'h0000_0100, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    chk("b2b_1_bus_addr", bus_addr, 32'h0000_0100);
    drive_req(32'h0000_3006, 1'b0, 32'h0, 4'h0);
    bus_ready = 1'b1;
    bus_rdata = 32'h1111_1111;
    @(negedge clk);
    bus_ready = 1'b0;
    chk("b2b_1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_1_rsp_rdata", rsp_rdata,      32'h1111_1111);
    chk("b2b_1_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("b2b_idle_ready", 32'(req_ready), 32'd1);
    chk("b2b_idle_bus",   32'(bus_valid), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_2_bus_valid", 32'(bus_valid), 32'd1);
    chk("b2b_2_bus_addr",  bus_addr,       32'h0000_3004);
    bus_ready = 1'b1;
    bus_rdata = 32'h2222_2222;
    @(negedge clk);
    bus_ready = 1'b0;
    chk("b2b_2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_2_rsp_rdata", rsp_rdata,      32'h2222_2222);
    @(negedge clk);

    // Reset during REQ drops the access; stray bus_ready afterwards is ignored
    drive_req(32'h0000_0500, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_bus_valid_pre", 32'(bus_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_bus_valid", 32'(bus_valid), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_busy",      32'(busy),      32'd0);
    rst_n     = 1'b1;
    bus_ready = 1'b1;
    bus_rdata = 32'h3333_3333;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_after_%0d_rsp", k),   32'(rsp_valid), 32'd0);
      chk($sformatf("rst_after_%0d_bus", k),   32'(bus_valid), 32'd0);
      chk($sformatf("rst_after_%0d_ready", k), 32'(req_ready), 32'd1);
    end
    bus_ready = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // No bus_ready: access times out after 8 REQ cycles
    begin
      int n = 0;
      drive_req(32'h0000_0600, 1'b0, 32'h0, 4'h0);
      @(negedge clk);
      req_valid = 1'b0;
      while (bus_valid === 1'b1 && n < 20) begin
        chk($sformatf("tmo_wait_%0d_rsp", n), 32'(rsp_valid), 32'd0);
        n++;
        @(negedge clk);
      end
      chk("tmo_req_cycles", 32'(n),         32'd8);
      chk("tmo_rsp_valid",  32'(rsp_valid), 32'd1);
      chk("tmo_rsp_err",    32'(rsp_err),   32'd1);
      chk("tmo_rsp_rdata",  rsp_rdata,      32'h0000_0013);
      @(negedge clk);
      chk("tmo_rsp_pulse",  32'(rsp_valid), 32'd0);
    end
    // bus_ready in the expiry cycle completes normally
    drive_req(32'h0000_0700, 1'b0, 32'h0, 4'h0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("tmo_win_%0d_bus", k), 32'(bus_valid), 32'd1);
      if (k == 7) begin
        bus_ready = 1'b1;
        bus_rdata = 32'h4444_4444;
      end
      @(negedge clk);
    end
    bus_ready = 1'b0;
    chk("tmo_win_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tmo_win_rsp_err",   32'(rsp_err),   32'd0);
    chk("tmo_win_rsp_rdata", rsp_rdata,      32'h4444_4444);
    @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
